// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: streams parallel bitstream words, MSB first, into a configuration flip-flop chain.
// Optional readback verify (ones-count compare via tail recirculation) is built when CCFF_READBACK_VERIFY_EN is defined.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_word,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              ccff_shift_en,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int MAX_L = (CHAIN_LEN > WORD_W) ? CHAIN_LEN : WORD_W;
  localparam int AW    = $clog2(MAX_L + 1);
  localparam logic [AW-1:0] CHAIN_LEN_A = AW'(CHAIN_LEN);
  localparam logic [AW-1:0] WORD_W_A    = AW'(WORD_W);
`ifdef CCFF_READBACK_VERIFY_EN
  localparam int BCW = $clog2(CHAIN_LEN + 1);
  localparam logic [BCW-1:0] VERIFY_LAST = BCW'(CHAIN_LEN - 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
`ifdef CCFF_READBACK_VERIFY_EN
    ST_VERIFY = 2'd2,
`endif
    ST_DONE   = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic [AW-1:0]     bit_cnt_r, bit_cnt_s;
  logic [AW-1:0]     acc_cnt_r, acc_cnt_s;
  logic [AW-1:0]     sh_cnt_r, sh_cnt_s;
  logic [AW-1:0]     hold_cnt_r, hold_cnt_s;
  logic [WORD_W-1:0] sh_r, sh_s;
  logic [WORD_W-1:0] hold_r, hold_s;
  logic              head_r, head_s;
  logic              shift_en_r, shift_en_s;
  logic              cfg_ready_r, cfg_ready_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic              err_r, err_s;
  logic [AW-1:0]     n_in_s;
  logic              xfer_s, pop_s, pop_bit_s, word_used_s;
`ifdef CCFF_READBACK_VERIFY_EN
  logic [BCW-1:0]    ones_in_r, ones_in_s;
  logic [BCW-1:0]    ones_out_r, ones_out_s;
  logic [BCW-1:0]    vcnt_r, vcnt_s;
`endif

  // The last word only contributes the bits still missing from the chain.
  function automatic logic [AW-1:0] take_bits(input logic [AW-1:0] accepted);
    logic [AW-1:0] remain;
    remain = CHAIN_LEN_A - accepted;
    if (remain > WORD_W_A) begin
      return WORD_W_A;
    end else begin
      return remain;
    end
  endfunction

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_s     = state_r;
    bit_cnt_s   = bit_cnt_r;
    acc_cnt_s   = acc_cnt_r;
    sh_s        = sh_r;
    sh_cnt_s    = sh_cnt_r;
    hold_s      = hold_r;
    hold_cnt_s  = hold_cnt_r;
    head_s      = head_r;
    shift_en_s  = 1'b0;
    err_s       = err_r;
    pop_s       = 1'b0;
    pop_bit_s   = 1'b0;
    word_used_s = 1'b0;
    xfer_s      = cfg_valid & cfg_ready_r;
    n_in_s      = take_bits(acc_cnt_r);
`ifdef CCFF_READBACK_VERIFY_EN
    ones_in_s   = ones_in_r;
    ones_out_s  = ones_out_r;
    vcnt_s      = vcnt_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s    = ST_SHIFT;
          err_s      = 1'b0;
          bit_cnt_s  = '0;
          acc_cnt_s  = '0;
          sh_cnt_s   = '0;
          hold_cnt_s = '0;
`ifdef CCFF_READBACK_VERIFY_EN
          ones_in_s  = '0;
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (bit_cnt_r == CHAIN_LEN_A) begin
`ifdef CCFF_READBACK_VERIFY_EN
          state_s    = ST_VERIFY;
          shift_en_s = 1'b1;
          vcnt_s     = '0;
          ones_out_s = '0;
`else
          state_s    = ST_DONE;
`endif
        end else begin
          // Bit source priority: shift register, then holding register, then the word arriving now.
          if (sh_cnt_r != '0) begin
            pop_s     = 1'b1;
            pop_bit_s = sh_r[WORD_W-1];
            sh_s      = sh_r << 1'b1;
            sh_cnt_s  = sh_cnt_r - AW'(1);
            if ((sh_cnt_s == '0) && (hold_cnt_r != '0)) begin
              sh_s       = hold_r;
              sh_cnt_s   = hold_cnt_r;
              hold_cnt_s = '0;
            end else begin
              hold_cnt_s = hold_cnt_r;
            end
          end else if (hold_cnt_r != '0) begin
            pop_s      = 1'b1;
            pop_bit_s  = hold_r[WORD_W-1];
            sh_s       = hold_r << 1'b1;
            sh_cnt_s   = hold_cnt_r - AW'(1);
            hold_cnt_s = '0;
          end else if (xfer_s) begin
            pop_s       = 1'b1;
            pop_bit_s   = cfg_word[WORD_W-1];
            sh_s        = cfg_word << 1'b1;
            sh_cnt_s    = n_in_s - AW'(1);
            word_used_s = 1'b1;
          end else begin
            pop_s = 1'b0;
          end
          if (xfer_s && !word_used_s) begin
            if (sh_cnt_s == '0) begin
              sh_s     = cfg_word;
              sh_cnt_s = n_in_s;
            end else begin
              hold_s     = cfg_word;
              hold_cnt_s = n_in_s;
            end
          end else begin
            hold_s = hold_r;
          end
          if (xfer_s) begin
            acc_cnt_s = acc_cnt_r + n_in_s;
          end else begin
            acc_cnt_s = acc_cnt_r;
          end
          if (pop_s) begin
            head_s     = pop_bit_s;
            shift_en_s = 1'b1;
            bit_cnt_s  = bit_cnt_r + AW'(1);
`ifdef CCFF_READBACK_VERIFY_EN
            ones_in_s  = ones_in_r + BCW'(pop_bit_s);
`endif
          end else begin
            head_s = head_r;
          end
        end
      end
`ifdef CCFF_READBACK_VERIFY_EN
      ST_VERIFY: begin
        ones_out_s = ones_out_r + BCW'(ccff_tail);
        vcnt_s     = vcnt_r + BCW'(1);
        if (vcnt_r == VERIFY_LAST) begin
          state_s    = ST_DONE;
          shift_en_s = 1'b0;
          if (ones_out_s != ones_in_r) begin
            err_s = 1'b1;
          end else begin
            err_s = err_r;
          end
        end else begin
          shift_en_s = 1'b1;
        end
      end
`endif
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    cfg_ready_s = (state_s == ST_SHIFT) && (hold_cnt_s == '0) && (acc_cnt_s < CHAIN_LEN_A);
`ifdef CCFF_READBACK_VERIFY_EN
    busy_s      = (state_s == ST_SHIFT) || (state_s == ST_VERIFY);
`else
    busy_s      = (state_s == ST_SHIFT);
`endif
    done_s      = (state_s == ST_DONE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge prog_clk) begin
    if (!pReset) begin
      state_r     <= ST_IDLE;
      bit_cnt_r   <= '0;
      acc_cnt_r   <= '0;
      sh_r        <= '0;
      sh_cnt_r    <= '0;
      hold_r      <= '0;
      hold_cnt_r  <= '0;
      head_r      <= 1'b0;
      shift_en_r  <= 1'b0;
      cfg_ready_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
`ifdef CCFF_READBACK_VERIFY_EN
      ones_in_r   <= '0;
      ones_out_r  <= '0;
      vcnt_r      <= '0;
`endif
    end else begin
      state_r     <= state_s;
      bit_cnt_r   <= bit_cnt_s;
      acc_cnt_r   <= acc_cnt_s;
      sh_r        <= sh_s;
      sh_cnt_r    <= sh_cnt_s;
      hold_r      <= hold_s;
      hold_cnt_r  <= hold_cnt_s;
      head_r      <= head_s;
      shift_en_r  <= shift_en_s;
      cfg_ready_r <= cfg_ready_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      err_r       <= err_s;
`ifdef CCFF_READBACK_VERIFY_EN
      ones_in_r   <= ones_in_s;
      ones_out_r  <= ones_out_s;
      vcnt_r      <= vcnt_s;
`endif
    end
  end

  assign cfg_ready     = cfg_ready_r;
  assign ccff_shift_en = shift_en_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign err           = err_r;

`ifdef CCFF_READBACK_VERIFY_EN
  // Recirculate the tail during verify so the chain content is preserved.
  assign ccff_head = (state_r == ST_VERIFY) ? ccff_tail : head_r;
`else
  logic unused_tail_s;
  assign ccff_head     = head_r;
  assign unused_tail_s = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Randomized bench for ccff_chain_loader (CHAIN_LEN=20, WORD_W=8) with a bit-stream and chain reference model.
module tb_ccff_chain_loader;

  localparam int CL = 20;
  localparam int WW = 8;
`ifdef CCFF_READBACK_VERIFY_EN
  localparam int VER = 1;
`else
  localparam int VER = 0;
`endif

  logic          prog_clk  = 1'b0;
  logic          pReset    = 1'b0;
  logic          start     = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          stuck     = 1'b0;
  logic [WW-1:0] cfg_word  = '0;
  logic          cfg_ready, ccff_head, ccff_tail, ccff_shift_en, busy, done, err;
  logic [CL-1:0] chain     = '0;
  int            total     = 0;
  int            bad       = 0;

  always #5 prog_clk = ~prog_clk;

  // Behavioural chain: the first bit shifted in ends at chain[CL-1], the tail.
  assign ccff_tail = stuck ? 1'b0 : chain[CL-1];
  always @(posedge prog_clk) begin
    if (ccff_shift_en) chain <= {chain[CL-2:0], ccff_head};
  end

  ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
    .prog_clk     (prog_clk),
    .pReset       (pReset),
    .start        (start),
    .cfg_word     (cfg_word),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .ccff_head    (ccff_head),
    .ccff_tail    (ccff_tail),
    .ccff_shift_en(ccff_shift_en),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One complete load: d = valid-low cycles between words 1 and 2, poke = stray start/valid, stk = tail stuck-at-0.
  task automatic run_load(input int d, input bit poke, input bit stk);
    logic [WW-1:0] w [3];
    bit            exp_q[$];
    logic [CL-1:0] expv;
    int widx = 0, gap_left = 0, cyc = 0, nshift = 0, gaps = 0;
    int acc0 = -1, first = -1, last = -1, dcyc = -1, exp_gaps;
    logic prev_head = 1'b0;
    logic err_at_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      w[i] = WW'($urandom);
      if (stk && i == 0) w[i][WW-1] = 1'b1;
      for (int b = WW-1; b >= 0; b--) begin
        if (exp_q.size() < CL) exp_q.push_back(w[i][b]);
      end
    end
    stuck = stk;
    @(negedge prog_clk); start = 1'b1;
    @(negedge prog_clk); start = 1'b0;
    check("busy_start", busy, 1);
    check("ready_start", cfg_ready, 1);
    check("err_clear", err, 0);
    while (dcyc < 0 && cyc < 300) begin
      if (done) begin
        dcyc = cyc;
        check("done_busy", busy, 0);
        check("done_shift", ccff_shift_en, 0);
        err_at_done = err;
        start = 1'b0;
        cfg_valid = 1'b0;
      end else begin
        check("busy_hold", busy, 1);
        if (ccff_shift_en) begin
          nshift++;
          last = cyc;
          if (first < 0) first = cyc;
          if (nshift <= CL) check("head_bit", ccff_head, exp_q[nshift-1]);
        end else if (nshift > 0 && nshift < CL) begin
          gaps++;
          check("head_hold", ccff_head, prev_head);
        end
        prev_head = ccff_head;
        if (widx == 3) check("ready_low", cfg_ready, 0);
        start = (poke && $urandom_range(0, 2) == 0) ? 1'b1 : 1'b0;
        if (widx < 3 && gap_left == 0) begin
          cfg_valid = 1'b1;
          cfg_word  = w[widx];
          if (cfg_ready) begin
            if (widx == 0) begin
              acc0 = cyc;
              gap_left = d;
            end
            widx++;
          end
        end else if (widx < 3) begin
          cfg_valid = 1'b0;
          cfg_word  = WW'($urandom);
          gap_left--;
        end else begin
          cfg_valid = poke;
          cfg_word  = WW'($urandom);
        end
        @(negedge prog_clk);
        cyc++;
      end
    end
    start = 1'b0;
    cfg_valid = 1'b0;
    exp_gaps = (d > WW-1) ? d - (WW-1) : 0;
    check("done_seen", dcyc >= 0, 1);
    check("shift_count", nshift, CL * (1 + VER));
    check("gap_count", gaps, exp_gaps);
    check("first_lat", first, acc0 + 1);
    check("done_lat", dcyc, last + 1);
    check("done_total", dcyc, first + CL * (1 + VER) + exp_gaps);
    check("err_done", err_at_done, (VER != 0) && stk);
    if (!((VER != 0) && stk)) begin
      for (int i = 0; i < CL; i++) expv[CL-1-i] = exp_q[i];
      check("chain", chain, expv);
    end
    @(negedge prog_clk);
    check("idle_after", {done, busy}, 0);
    stuck = 1'b0;
  endtask

  initial begin
    pReset = 1'b0;
    repeat (3) @(negedge prog_clk);
    check("rst_outs", {cfg_ready, ccff_head, ccff_shift_en, busy, done, err}, 0);
    pReset = 1'b1;
    @(negedge prog_clk);
    check("idle_outs", {cfg_ready, ccff_shift_en, busy, done}, 0);

    run_load(0, 1'b0, 1'b0);
    run_load(12, 1'b0, 1'b0);
    run_load(0, 1'b1, 1'b0);
    run_load(7, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) run_load($urandom_range(0, 14), 1'($urandom_range(0, 1)), 1'b0);

    @(negedge prog_clk); start = 1'b1;
    @(negedge prog_clk); start = 1'b0;
    cfg_valid = 1'b1;
    cfg_word  = WW'($urandom);
    repeat (5) @(negedge prog_clk);
    check("pre_rst_busy", busy, 1);
    pReset = 1'b0;
    cfg_valid = 1'b0;
    @(negedge prog_clk);
    check("rst_mid1", {cfg_ready, ccff_head, ccff_shift_en, busy, done, err}, 0);
    @(negedge prog_clk);
    check("rst_mid2", {cfg_ready, ccff_head, ccff_shift_en, busy, done, err}, 0);
    pReset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge prog_clk);
      check("no_done_after_rst", {done, busy, ccff_shift_en}, 0);
    end
    run_load(3, 1'b0, 1'b0);

    run_load(0, 1'b0, 1'b1);
    repeat (3) @(negedge prog_clk);
    check("err_sticky", err, VER);
    run_load(2, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
